// File: rtl/cond_pkg.sv
// cond_pkg: shared condition codes, NZCV bit positions and control bundle for the flag unit
package cond_pkg;
  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  localparam int FLAGW_NZ = 1;
  localparam int FLAGW_CV = 0;

  typedef struct packed {
    logic condex;
    logic pcsrc;
    logic regwrite;
    logic memwrite;
    logic commit;
    logic undef;
  } ctrl_t;
endpackage

// File: rtl/cond_check.sv
// cond_check: combinational ARM condition-field evaluation against an NZCV value
module cond_check
  import cond_pkg::*;
(
  input  logic [3:0] Cond,
  input  logic [3:0] Flags,
  output logic       pass,
  output logic       undef
);
  logic n, z, c, v;
  assign n = Flags[FLAG_N];
  assign z = Flags[FLAG_Z];
  assign c = Flags[FLAG_C];
  assign v = Flags[FLAG_V];
  always_comb begin
    pass = 1'b0;
    case (Cond)
      COND_EQ: pass = z;
      COND_NE: pass = ~z;
      COND_CS: pass = c;
      COND_CC: pass = ~c;
      COND_MI: pass = n;
      COND_PL: pass = ~n;
      COND_VS: pass = v;
      COND_VC: pass = ~v;
      COND_HI: pass = c & ~z;
      COND_LS: pass = ~c | z;
      COND_GE: pass = n == v;
      COND_LT: pass = n != v;
      COND_GT: pass = ~z & (n == v);
      COND_LE: pass = z | (n != v);
      COND_AL: pass = 1'b1;
      default: pass = 1'b0;
    endcase
  end
  assign undef = Cond == COND_NV;
endmodule

// File: rtl/cond_unit.sv
// cond_unit: NZCV flag register, condition check and registered gated write controls.
// Optional COND_PERF_CNT_EN adds exec_cnt/skip_cnt pass/fail counters.
module cond_unit
  import cond_pkg::*;
#(
  parameter logic [3:0] RESET_FLAGS = 4'b0000
`ifdef COND_PERF_CNT_EN
  , parameter int CNT_WIDTH = 16
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       exec,
  input  logic       stall,
  input  logic [3:0] Cond,
  input  logic [3:0] ALUFlags,
  input  logic [1:0] FlagW,
  input  logic       PCS,
  input  logic       RegW,
  input  logic       MemW,
  input  logic       NoWrite,
  output logic [3:0] Flags,
  output logic       CondEx,
  output logic       PCSrc,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       commit,
  output logic       cond_undef
`ifdef COND_PERF_CNT_EN
  , output logic [CNT_WIDTH-1:0] exec_cnt
  , output logic [CNT_WIDTH-1:0] skip_cnt
`endif
);
  logic pass, undef;
  logic upd_nz, upd_cv;
  logic [3:0] flags_d;
  ctrl_t ctrl_q, ctrl_d;
  cond_check u_check (
    .Cond  (Cond),
    .Flags (Flags),
    .pass  (pass),
    .undef (undef)
  );
  // pass comes from the registered flags, so a failed condition can never update them
  assign upd_nz = exec & pass & FlagW[FLAGW_NZ];
  assign upd_cv = exec & pass & FlagW[FLAGW_CV];
  always_comb begin
    flags_d = Flags;
    flags_d[FLAG_N:FLAG_Z] = upd_nz ? ALUFlags[FLAG_N:FLAG_Z] : Flags[FLAG_N:FLAG_Z];
    flags_d[FLAG_C:FLAG_V] = upd_cv ? ALUFlags[FLAG_C:FLAG_V] : Flags[FLAG_C:FLAG_V];
    ctrl_d = '0;
    ctrl_d.condex = exec ? pass : ctrl_q.condex;
    ctrl_d.pcsrc = exec & PCS & pass;
    ctrl_d.regwrite = exec & RegW & ~NoWrite & pass;
    ctrl_d.memwrite = exec & MemW & pass;
    ctrl_d.commit = exec;
    ctrl_d.undef = exec & undef;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      Flags <= RESET_FLAGS;
      ctrl_q <= '0;
    end else if (!stall) begin
      Flags <= flags_d;
      ctrl_q <= ctrl_d;
    end
  end
  assign CondEx = ctrl_q.condex;
  assign PCSrc = ctrl_q.pcsrc;
  assign RegWrite = ctrl_q.regwrite;
  assign MemWrite = ctrl_q.memwrite;
  assign commit = ctrl_q.commit;
  assign cond_undef = ctrl_q.undef;
`ifdef COND_PERF_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      exec_cnt <= '0;
      skip_cnt <= '0;
    end else if (!stall && exec) begin
      if (pass) exec_cnt <= exec_cnt + CNT_WIDTH'(1);
      else skip_cnt <= skip_cnt + CNT_WIDTH'(1);
    end
  end
`endif
endmodule

// File: tb/tb_cond_unit.sv
// tb_cond_unit: directed vectors into a scoreboard queue, checked by a commit-driven monitor
module tb_cond_unit;
  import cond_pkg::*;
  localparam int CW = 2;
  logic clk = 1'b0, reset = 1'b1, exec = 1'b0, stall = 1'b0;
  logic [3:0] Cond = '0, ALUFlags = '0;
  logic [1:0] FlagW = '0;
  logic PCS = 1'b0, RegW = 1'b0, MemW = 1'b0, NoWrite = 1'b0;
  logic [3:0] Flags;
  logic CondEx, PCSrc, RegWrite, MemWrite, commit, cond_undef;
`ifdef COND_PERF_CNT_EN
  logic [CW-1:0] exec_cnt, skip_cnt;
`endif
  cond_unit #(
    .RESET_FLAGS (4'b0000)
`ifdef COND_PERF_CNT_EN
    , .CNT_WIDTH (CW)
`endif
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .exec       (exec),
    .stall      (stall),
    .Cond       (Cond),
    .ALUFlags   (ALUFlags),
    .FlagW      (FlagW),
    .PCS        (PCS),
    .RegW       (RegW),
    .MemW       (MemW),
    .NoWrite    (NoWrite),
    .Flags      (Flags),
    .CondEx     (CondEx),
    .PCSrc      (PCSrc),
    .RegWrite   (RegWrite),
    .MemWrite   (MemWrite),
    .commit     (commit),
    .cond_undef (cond_undef)
`ifdef COND_PERF_CNT_EN
    , .exec_cnt (exec_cnt)
    , .skip_cnt (skip_cnt)
`endif
  );
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] flags;
    logic condex, pcsrc, regw, memw, undef;
    int ecnt, scnt;
  } exp_t;
  exp_t q[$];
  int checks = 0, failures = 0;
  int ecnt = 0, scnt = 0;
  logic last_ok = 1'b0, last_exec = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [3:0] c, input logic [3:0] af, input logic [1:0] fw,
                       input logic pcs, input logic rw, input logic mw, input logic nw,
                       input logic [3:0] ef, input logic ec, input logic ep,
                       input logic er, input logic em, input logic eu);
    @(negedge clk);
    exec = 1'b1;
    Cond = c;
    ALUFlags = af;
    FlagW = fw;
    PCS = pcs;
    RegW = rw;
    MemW = mw;
    NoWrite = nw;
    if (ec) ecnt++;
    else scnt++;
    q.push_back('{ef, ec, ep, er, em, eu, ecnt, scnt});
  endtask

  always @(posedge clk) begin
    last_ok <= !reset && !stall;
    last_exec <= exec;
  end

  // a commit seen after a non-stalled edge is a fresh result and must match the queue head
  always @(negedge clk) begin
    exp_t e;
    if (!reset && last_ok) begin
      chk("commit", commit, last_exec);
      if (commit) begin
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_commit: got commit=1 required empty scoreboard");
        end else begin
          e = q.pop_front();
          chk("flags", Flags, e.flags);
          chk("condex", CondEx, e.condex);
          chk("pcsrc", PCSrc, e.pcsrc);
          chk("regwrite", RegWrite, e.regw);
          chk("memwrite", MemWrite, e.memw);
          chk("cond_undef", cond_undef, e.undef);
`ifdef COND_PERF_CNT_EN
          chk("exec_cnt", exec_cnt, e.ecnt % (1 << CW));
          chk("skip_cnt", skip_cnt, e.scnt % (1 << CW));
`endif
        end
      end
    end
  end

  initial begin
    int n;
    repeat (2) @(negedge clk);
    chk("rst_flags", Flags, 4'h0);
    chk("rst_condex", CondEx, 0);
    chk("rst_commit", commit, 0);
    chk("rst_undef", cond_undef, 0);
    #1 reset = 1'b0;
    @(negedge clk);
    exec = 1'b1; Cond = COND_AL; FlagW = 2'b11; ALUFlags = 4'hF; PCS = 1'b1; RegW = 1'b1; MemW = 1'b1;
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("async_flags", Flags, 4'h0);
    chk("async_commit", commit, 0);
    chk("async_condex", CondEx, 0);
    chk("async_pcsrc", PCSrc, 0);
    chk("async_regwrite", RegWrite, 0);
    chk("async_memwrite", MemWrite, 0);
    @(negedge clk);
    exec = 1'b0; PCS = 1'b0; RegW = 1'b0; MemW = 1'b0; FlagW = 2'b00;
    #1 reset = 1'b0;
    @(negedge clk);
    chk("post_rst_flags", Flags, 4'h0);
`ifdef COND_PERF_CNT_EN
    chk("post_rst_exec_cnt", exec_cnt, 0);
    chk("post_rst_skip_cnt", skip_cnt, 0);
`endif
    //     cond     aluf   fw    pcs rw mw nw  flags  ec ep er em eu
    issue(COND_AL, 4'h4, 2'b11, 0, 1, 0, 0, 4'h4, 1, 0, 1, 0, 0);
    issue(COND_EQ, 4'h0, 2'b00, 0, 1, 0, 0, 4'h4, 1, 0, 1, 0, 0);
    issue(COND_NE, 4'h0, 2'b00, 0, 1, 0, 0, 4'h4, 0, 0, 0, 0, 0);
    issue(COND_NE, 4'hB, 2'b11, 0, 0, 0, 0, 4'h4, 0, 0, 0, 0, 0);
    issue(COND_AL, 4'h9, 2'b11, 0, 0, 0, 0, 4'h9, 1, 0, 0, 0, 0);
    issue(COND_GE, 4'h0, 2'b00, 1, 0, 0, 0, 4'h9, 1, 1, 0, 0, 0);
    issue(COND_LT, 4'h0, 2'b00, 1, 0, 0, 0, 4'h9, 0, 0, 0, 0, 0);
    issue(COND_AL, 4'h6, 2'b01, 0, 0, 0, 0, 4'hA, 1, 0, 0, 0, 0);
    issue(COND_AL, 4'h0, 2'b00, 0, 1, 1, 1, 4'hA, 1, 0, 0, 1, 0);
    issue(COND_NV, 4'h5, 2'b11, 1, 1, 1, 0, 4'hA, 0, 0, 0, 0, 1);
    issue(COND_HI, 4'h4, 2'b10, 1, 0, 0, 0, 4'h6, 1, 1, 0, 0, 0);
    issue(COND_GT, 4'h0, 2'b00, 0, 1, 0, 0, 4'h6, 0, 0, 0, 0, 0);
    issue(COND_LE, 4'h0, 2'b00, 0, 1, 0, 0, 4'h6, 1, 0, 1, 0, 0);
    issue(COND_MI, 4'h0, 2'b00, 0, 0, 0, 0, 4'h6, 0, 0, 0, 0, 0);
    issue(COND_PL, 4'h0, 2'b00, 0, 0, 0, 0, 4'h6, 1, 0, 0, 0, 0);
    issue(COND_CS, 4'h0, 2'b00, 0, 0, 0, 0, 4'h6, 1, 0, 0, 0, 0);
    issue(COND_CC, 4'h0, 2'b00, 0, 0, 0, 0, 4'h6, 0, 0, 0, 0, 0);
    issue(COND_VS, 4'h0, 2'b00, 0, 0, 0, 0, 4'h6, 0, 0, 0, 0, 0);
    issue(COND_VC, 4'h0, 2'b00, 0, 0, 0, 0, 4'h6, 1, 0, 0, 0, 0);
    issue(COND_LS, 4'h0, 2'b00, 0, 0, 1, 0, 4'h6, 1, 0, 0, 1, 0);
    issue(COND_GE, 4'h0, 2'b00, 0, 0, 0, 0, 4'h6, 1, 0, 0, 0, 0);
    issue(COND_LT, 4'h0, 2'b00, 0, 0, 0, 0, 4'h6, 0, 0, 0, 0, 0);
    issue(COND_EQ, 4'h0, 2'b00, 0, 0, 0, 0, 4'h6, 1, 0, 0, 0, 0);
    issue(COND_HI, 4'h0, 2'b00, 1, 0, 0, 0, 4'h6, 0, 0, 0, 0, 0);
    issue(COND_NE, 4'hF, 2'b01, 0, 0, 0, 0, 4'h6, 0, 0, 0, 0, 0);
    @(negedge clk);
    exec = 1'b1; stall = 1'b1; Cond = COND_AL; ALUFlags = 4'hF; FlagW = 2'b11;
    PCS = 1'b0; RegW = 1'b0; MemW = 1'b0; NoWrite = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_flags", Flags, 4'h6);
      chk("stall_commit", commit, 1);
`ifdef COND_PERF_CNT_EN
      chk("stall_exec_cnt", exec_cnt, ecnt % (1 << CW));
      chk("stall_skip_cnt", skip_cnt, scnt % (1 << CW));
`endif
    end
    stall = 1'b0;
    ecnt++;
    q.push_back('{4'hF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, ecnt, scnt});
    @(negedge clk);
    exec = 1'b0;
    n = 0;
    while (q.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    repeat (2) @(negedge clk);
    chk("idle_flags", Flags, 4'hF);
    chk("idle_condex", CondEx, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
